// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus controller.
// The optional power-on init sequence is enabled by defining LCD_INIT_SEQ_EN.
package lcd_pkg;

    localparam int unsigned LCD_ON_BIT = 31;
    localparam int unsigned LCD_RS_BIT = 10;
    localparam int unsigned LCD_EN_BIT = 8;

    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
    localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;

    localparam int unsigned LCD_INIT_LEN = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT,
        ST_PWR_WAIT
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_clear_home(input lcd_entry_t e);
        return !e.rs && ((e.data == LCD_CMD_CLEAR) || (e.data == LCD_CMD_HOME) ||
                         (e.data == (LCD_CMD_CLEAR | LCD_CMD_HOME)));
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = LCD_CMD_FUNC_SET;
            2'd1:    cmd = LCD_CMD_DISP_ON;
            2'd2:    cmd = LCD_CMD_CLEAR;
            default: cmd = LCD_CMD_ENTRY;
        endcase
        return cmd;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO with registered count/full/empty and flush.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  lcd_entry_t wdata,
    output lcd_entry_t rdata_c,
    output logic       full,
    output logic       empty,
    output logic       empty_nxt_c,
    output logic       drop_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    lcd_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              push_ok;
    logic              pop_ok;

    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && !flush && (!full || pop_ok);
    assign drop_c  = push && !flush && full && !pop_ok;
    assign rdata_c = mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    assign empty_nxt_c = (count_d == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full    <= (count_d == CNT_W'(DEPTH));
            empty   <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/lcd_bus_ctrl.sv
// Turns core LCD register writes into timed HD44780 bus cycles via a command queue.
// Define LCD_INIT_SEQ_EN to add the power-on delay and internal init command sequence.
module lcd_bus_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned T_SETUP_CYC = 4,
    parameter int unsigned T_EN_CYC    = 25,
    parameter int unsigned T_HOLD_CYC  = 2,
    parameter int unsigned T_EXEC_CYC  = 2500,
    parameter int unsigned T_CLR_CYC   = 82000,
    parameter int unsigned T_PWR_CYC   = 750000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_io_lcd,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_ovf
);

    localparam int unsigned T_MAX = max_u(max_u(max_u(T_SETUP_CYC, T_EN_CYC),
                                                max_u(T_HOLD_CYC, T_EXEC_CYC)),
                                          max_u(T_CLR_CYC, T_PWR_CYC));
    localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

    localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] C_EN    = CNT_W'(T_EN_CYC - 1);
    localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] C_EXEC  = CNT_W'(T_EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] C_CLR   = CNT_W'(T_CLR_CYC - 1);
    localparam logic [CNT_W-1:0] C_PWR   = CNT_W'(T_PWR_CYC - 1);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             en_q, en_d;
    logic             clr_q, clr_d;
    logic             busy_d;
    logic             on_q;
    logic             en_prev_q;
    logic             ovf_q;
    logic             busy_q;
    logic             cnt_zero;

    logic             push_c;
    logic             pop_c;
    lcd_entry_t       push_entry_c;
    lcd_entry_t       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_empty_nxt;
    logic             fifo_drop;
    logic             unused_io_bits;

`ifdef LCD_INIT_SEQ_EN
    logic             init_done_q, init_done_d;
    logic [1:0]       init_idx_q, init_idx_d;
    lcd_entry_t       init_entry;
`endif

    assign unused_io_bits = ^{i_io_lcd[30:11], i_io_lcd[9]};

    // New command on the EN strobe rising edge, only while the display is on.
    assign push_c       = i_io_lcd[LCD_EN_BIT] && !en_prev_q && i_io_lcd[LCD_ON_BIT];
    assign push_entry_c = '{rs: i_io_lcd[LCD_RS_BIT], data: i_io_lcd[7:0]};
    assign cnt_zero     = (cnt_q == '0);

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (i_clk),
        .reset       (i_reset),
        .flush       (!on_q),
        .push        (push_c),
        .pop         (pop_c),
        .wdata       (push_entry_c),
        .rdata_c     (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .empty_nxt_c (fifo_empty_nxt),
        .drop_c      (fifo_drop)
    );

    always_comb begin : fsm_next
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        en_d    = en_q;
        clr_d   = clr_q;
        pop_c   = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        init_done_d = init_done_q;
        init_idx_d  = init_idx_q;
        init_entry  = '{rs: 1'b0, data: init_cmd(init_idx_q)};
`endif
        if (!on_q) begin
            // Display switched off: abandon the current bus cycle and the queue.
            en_d = 1'b0;
`ifdef LCD_INIT_SEQ_EN
            if (init_done_q) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                state_d    = ST_PWR_WAIT;
                cnt_d      = C_PWR;
                init_idx_d = '0;
            end
`else
            state_d = ST_IDLE;
            cnt_d   = '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
`ifdef LCD_INIT_SEQ_EN
                    if (!init_done_q) begin
                        rs_d        = init_entry.rs;
                        data_d      = init_entry.data;
                        clr_d       = is_clear_home(init_entry);
                        init_idx_d  = init_idx_q + 2'd1;
                        init_done_d = (init_idx_q == 2'(LCD_INIT_LEN - 1));
                        state_d     = ST_SETUP;
                        cnt_d       = C_SETUP;
                    end else if (!fifo_empty) begin
`else
                    if (!fifo_empty) begin
`endif
                        pop_c   = 1'b1;
                        rs_d    = fifo_head.rs;
                        data_d  = fifo_head.data;
                        clr_d   = is_clear_home(fifo_head);
                        state_d = ST_SETUP;
                        cnt_d   = C_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_zero) begin
                        state_d = ST_EN_HI;
                        en_d    = 1'b1;
                        cnt_d   = C_EN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_EN_HI: begin
                    if (cnt_zero) begin
                        state_d = ST_HOLD;
                        en_d    = 1'b0;
                        cnt_d   = C_HOLD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero) begin
                        state_d = ST_WAIT;
                        cnt_d   = clr_q ? C_CLR : C_EXEC;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_WAIT, ST_PWR_WAIT: begin
                    if (cnt_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin : busy_next
`ifdef LCD_INIT_SEQ_EN
        busy_d = (state_d != ST_IDLE) || !fifo_empty_nxt || !init_done_d;
`else
        busy_d = (state_d != ST_IDLE) || !fifo_empty_nxt;
`endif
    end

    always_ff @(posedge i_clk) begin : fsm_regs
        if (i_reset) begin
`ifdef LCD_INIT_SEQ_EN
            state_q     <= ST_PWR_WAIT;
            cnt_q       <= C_PWR;
            init_done_q <= 1'b0;
            init_idx_q  <= '0;
`else
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
`endif
            rs_q        <= 1'b0;
            data_q      <= '0;
            en_q        <= 1'b0;
            clr_q       <= 1'b0;
            on_q        <= 1'b0;
            en_prev_q   <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            en_q        <= en_d;
            clr_q       <= clr_d;
            on_q        <= i_io_lcd[LCD_ON_BIT];
            en_prev_q   <= i_io_lcd[LCD_EN_BIT];
            busy_q      <= busy_d;
            if (fifo_drop) ovf_q <= 1'b1;
`ifdef LCD_INIT_SEQ_EN
            init_done_q <= init_done_d;
            init_idx_q  <= init_idx_d;
`endif
        end
    end

    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;
    assign o_busy     = busy_q;
    assign o_ovf      = ovf_q;

    // Full flag is implied by the drop strobe; kept as a port of the queue for reuse.
    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Self-checking bench for lcd_bus_ctrl: vector table, EN-pulse scoreboard, corner sequences.
module tb_lcd_bus_ctrl;

    localparam logic [31:0] EN_M = 32'h0000_0100;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        logic        rs;
        logic [7:0]  data;
        int          busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_io_lcd;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic        o_lcd_en;
    logic        o_lcd_on;
    logic        o_busy;
    logic        o_ovf;

    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    int   n_rise = 0;
    int   last_rise = 0;
    int   last_width = 0;
    int   rise_log[$];
    exp_t sb_q[$];
    exp_t cur;
    logic en_d1 = 1'b0;

    lcd_bus_ctrl #(
        .FIFO_DEPTH  (4),
        .T_SETUP_CYC (2),
        .T_EN_CYC    (3),
        .T_HOLD_CYC  (1),
        .T_EXEC_CYC  (10),
        .T_CLR_CYC   (40),
        .T_PWR_CYC   (20)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_io_lcd   (i_io_lcd),
        .o_lcd_data (o_lcd_data),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_on   (o_lcd_on),
        .o_busy     (o_busy),
        .o_ovf      (o_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every EN rising edge must carry the oldest expected command.
    always @(negedge clk) begin
        if (o_lcd_en && !en_d1) begin
            n_rise++;
            last_rise = cyc;
            rise_log.push_back(cyc);
            if (sb_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL sb_unexpected_pulse: got data %0h with no expected entry (cycle %0d)",
                         o_lcd_data, cyc);
            end else begin
                cur = sb_q.pop_front();
                check("sb_rs", int'(o_lcd_rs), int'(cur.rs));
                check("sb_data", int'(o_lcd_data), int'(cur.data));
            end
        end
        if (!o_lcd_en && en_d1) begin
            last_width = cyc - last_rise;
            check("hold_data", int'(o_lcd_data), int'(cur.data));
        end
        en_d1 = o_lcd_en;
    end

    task automatic strobe(input logic [31:0] w, output int pc);
        @(posedge clk); #1;
        i_io_lcd = w | EN_M;
        pc = cyc + 1;
        @(posedge clk); #1;
        i_io_lcd = w & ~EN_M;
    endtask

    task automatic expect_cmd(input logic rs, input logic [7:0] data);
        exp_t e;
        e.rs   = rs;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int bound, output int fall);
        fall = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (!o_busy) begin
                fall = cyc;
                return;
            end
        end
        nchk++;
        nerr++;
        $display("FAIL %s: busy still high after %0d cycles, required low", name, bound);
    endtask

    // Waits (bounded) for the n-th EN rising edge seen from now; returns at that negedge.
    task automatic wait_rises(input string name, input int n, input int bound);
        int   k;
        logic prev;
        k = 0;
        prev = o_lcd_en;
        for (int t = 0; t < bound; t++) begin
            @(negedge clk);
            if (o_lcd_en && !prev) k++;
            prev = o_lcd_en;
            if (k == n) return;
        end
        nchk++;
        nerr++;
        $display("FAIL %s: saw %0d EN pulses, required %0d", name, k, n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        int   pc, fall, n0, nfirst;

        vecs[0] = '{32'h8000_0541, 1'b1, 8'h41, 17};
        vecs[1] = '{32'h8000_0101, 1'b0, 8'h01, 47};
        vecs[2] = '{32'h8000_0102, 1'b0, 8'h02, 47};
        vecs[3] = '{32'h8000_0103, 1'b0, 8'h03, 47};
        vecs[4] = '{32'h8000_0104, 1'b0, 8'h04, 17};
        vecs[5] = '{32'h8000_0501, 1'b1, 8'h01, 17};
        vecs[6] = '{32'h8000_0738, 1'b1, 8'h38, 17};
        vecs[7] = '{32'h8000_0100, 1'b0, 8'h00, 17};

        // Reset state
        i_reset  = 1'b1;
        i_io_lcd = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_data", int'(o_lcd_data), 0);
        check("rst_rs", int'(o_lcd_rs), 0);
        check("rst_rw", int'(o_lcd_rw), 0);
        check("rst_en", int'(o_lcd_en), 0);
        check("rst_on", int'(o_lcd_on), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_ovf", int'(o_ovf), 0);
        i_io_lcd = 32'h8000_0000;
        @(negedge clk);
        i_reset = 1'b0;

`ifdef LCD_INIT_SEQ_EN
        // Power-on delay, four init commands, then a user write queued during init.
        expect_cmd(1'b0, 8'h38);
        expect_cmd(1'b0, 8'h0C);
        expect_cmd(1'b0, 8'h01);
        expect_cmd(1'b0, 8'h06);
        repeat (20) @(negedge clk);
        check("init_no_en_pwr", n_rise, 0);
        check("init_busy", int'(o_busy), 1);
        expect_cmd(1'b1, 8'hAA);
        strobe(32'h8000_05AA, pc);
        wait_idle("init_idle", 1000, fall);
        check("init_pulses", n_rise, 5);
        check("init_sb_empty", sb_q.size(), 0);
`else
        repeat (2) @(negedge clk);
        check("on_follow", int'(o_lcd_on), 1);
`endif

        // Single commands from the vector table
        for (int i = 0; i < 8; i++) begin
            expect_cmd(vecs[i].rs, vecs[i].data);
            strobe(vecs[i].word, pc);
            wait_idle($sformatf("vec%0d_idle", i), 200, fall);
            check($sformatf("vec%0d_en_lat", i), last_rise - pc, 3);
            check($sformatf("vec%0d_busy_lat", i), fall - pc, vecs[i].busy);
            check($sformatf("vec%0d_en_width", i), last_width, 3);
            check($sformatf("vec%0d_rs_keep", i), int'(o_lcd_rs), int'(vecs[i].rs));
            check($sformatf("vec%0d_data_keep", i), int'(o_lcd_data), int'(vecs[i].data));
            check($sformatf("vec%0d_rw", i), int'(o_lcd_rw), 0);
        end

        // Clear followed by a queued write: long wait before the next bus cycle
        expect_cmd(1'b0, 8'h01);
        expect_cmd(1'b1, 8'h48);
        strobe(32'h8000_0101, pc);
        strobe(32'h8000_0548, pc);
        wait_idle("clr_idle", 300, fall);
        check("clr_spacing", rise_log[rise_log.size()-1] - rise_log[rise_log.size()-2], 47);

        // Burst of six EN edges two cycles apart: sixth overflows
        check("ovf_pre", int'(o_ovf), 0);
        n0 = n_rise;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            i_io_lcd = 32'h8000_0500 | 32'(8'h10 + i) | EN_M;
            if (i < 5) expect_cmd(1'b1, 8'(8'h10 + i));
            @(posedge clk); #1;
            i_io_lcd = i_io_lcd & ~EN_M;
        end
        @(negedge clk);
        check("burst_ovf", int'(o_ovf), 1);
        wait_idle("burst_idle", 400, fall);
        check("burst_pulses", n_rise - n0, 5);
        check("burst_spacing", rise_log[rise_log.size()-1] - rise_log[rise_log.size()-2], 17);
        check("burst_sb_empty", sb_q.size(), 0);

        // ON dropped during the second pulse with three commands still queued
        n0 = n_rise;
        expect_cmd(1'b1, 8'h61);
        expect_cmd(1'b1, 8'h62);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            i_io_lcd = 32'h8000_0500 | 32'(8'h61 + i) | EN_M;
            @(posedge clk); #1;
            i_io_lcd = i_io_lcd & ~EN_M;
        end
        wait_rises("off_second_pulse", 1, 60);
        check("off_en_before", int'(o_lcd_en), 1);
        i_io_lcd = 32'h0000_0000;
        repeat (2) @(negedge clk);
        check("off_en_forced", int'(o_lcd_en), 0);
        check("off_busy", int'(o_busy), 0);
        check("off_on", int'(o_lcd_on), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            i_io_lcd = 32'h0000_0570 | EN_M;
            @(posedge clk); #1;
            i_io_lcd = 32'h0000_0570;
        end
        i_io_lcd = 32'h8000_0000;
        repeat (60) @(negedge clk);
        check("off_pulses", n_rise - n0, 2);
        check("off_busy_after", int'(o_busy), 0);
        check("off_ovf_kept", int'(o_ovf), 1);
        check("off_sb_empty", sb_q.size(), 0);

        // Reset during WAIT with two commands queued
        n0 = n_rise;
        expect_cmd(1'b1, 8'h71);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            i_io_lcd = 32'h8000_0500 | 32'(8'h71 + i) | EN_M;
            @(posedge clk); #1;
            i_io_lcd = i_io_lcd & ~EN_M;
        end
        nfirst = n_rise;
        check("rstw_first_pulse", nfirst - n0, 1);
        repeat (5) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        check("rstw_data", int'(o_lcd_data), 0);
        check("rstw_rs", int'(o_lcd_rs), 0);
        check("rstw_en", int'(o_lcd_en), 0);
        check("rstw_on", int'(o_lcd_on), 0);
        check("rstw_busy", int'(o_busy), 0);
        check("rstw_ovf", int'(o_ovf), 0);
        i_reset = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        expect_cmd(1'b0, 8'h38);
        expect_cmd(1'b0, 8'h0C);
        expect_cmd(1'b0, 8'h01);
        expect_cmd(1'b0, 8'h06);
        repeat (30) @(negedge clk);
        wait_idle("rstw_idle", 1000, fall);
        check("rstw_pulses", n_rise - n0, 5);
`else
        repeat (80) @(negedge clk);
        wait_idle("rstw_idle", 10, fall);
        check("rstw_pulses", n_rise - n0, 1);
`endif
        check("rstw_on_after", int'(o_lcd_on), 1);
        check("rstw_ovf_after", int'(o_ovf), 0);
        check("final_sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
